// File: rtl/cache_pkg.sv
// cache_pkg: constants and types shared by the cache refill controller and
// the cache itself.
//   BLOCK_WORDS : 32-bit words per cache block (32-byte block)
//   WORD_OFF_W  : byte-in-word offset bits, ignored by the refill path
//   IDX_W       : word-in-block index width
//   OFF_W       : full byte-in-block offset width
//   refill_state_e : refill FSM state encoding
package cache_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_OFF_W  = 2;
  localparam int IDX_W       = $clog2(BLOCK_WORDS);
  localparam int OFF_W       = IDX_W + WORD_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_DONE      = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: single-word memory handshake used by the refill
// controller. A beat is a cycle with mem_req=1 and mem_ready=1; the master
// holds mem_req/mem_we/mem_addr/mem_wdata stable until that beat.
//   master : controller side (drives request, address, write data)
//   slave  : memory side (drives read data and ready)
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_refill_beat_cnt.sv
// cache_refill_beat_cnt: word-index counter for one burst phase.
//   load  : restart the burst at word index start
//   inc   : advance one word (index wraps modulo BLOCK_WORDS)
//   idx   : current word index
//   last  : current word is the final one of the burst
// The beat count is kept apart from the index so a burst that starts
// mid-block still ends after exactly BLOCK_WORDS beats.
module cache_refill_beat_cnt #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           inc,
  input  logic [$clog2(BLOCK_WORDS)-1:0] start,
  output logic [$clog2(BLOCK_WORDS)-1:0] idx,
  output logic                           last
);
  localparam int IW = $clog2(BLOCK_WORDS);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start;
      cnt_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + IW'(1);
      cnt_q <= cnt_q + IW'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == IW'(BLOCK_WORDS - 1));
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: on a cache miss, optionally writes the dirty victim
// block back to memory, then fetches the missing block one word per beat
// and writes each word into the cache line.
//   clk, reset       : clock, asynchronous active-low reset
//   miss_req/addr    : refill request and missing byte address
//   wb_dirty/wb_addr : victim dirty flag and victim block address
//   wb_word_idx/word : victim word read port into the cache
//   refill_*         : line write port and completion pulse
//   busy             : controller not idle
//   mem              : single-word memory handshake (master side)
// Build option: CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the
// missing word instead of word 0; the writeback always starts at word 0.
module cache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           miss_req,
  input  logic [ADDR_W-1:0]              miss_addr,
  input  logic                           wb_dirty,
  input  logic [ADDR_W-1:0]              wb_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] wb_word_idx,
  input  logic [31:0]                    wb_word,
  output logic                           refill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] refill_word_idx,
  output logic [31:0]                    refill_data,
  output logic                           refill_done,
  output logic                           busy,
  cache_refill_ctrl_if.master            mem
);
  import cache_pkg::*;

  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int OW = IW + WORD_OFF_W;
  localparam int BW = ADDR_W - OW;

  refill_state_e state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [BW-1:0] wb_blk_q;
  logic [BW-1:0] miss_blk_q;
  logic [IW-1:0] miss_start_q;
  logic          refill_we_q;
  logic          refill_done_q;
  logic [IW-1:0] refill_idx_q;
  logic [31:0]   refill_data_q;

  logic          beat;
  logic          cnt_load;
  logic          cnt_inc;
  logic          cnt_last;
  logic [IW-1:0] cnt_start;
  logic [IW-1:0] cnt_idx;
  logic [IW-1:0] miss_start_d;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign miss_start_d = miss_addr[OW-1:WORD_OFF_W];
`else
  assign miss_start_d = '0;
`endif

  // Offset bits never form part of a block address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr[OW-1:0], wb_addr[OW-1:0]};

  assign beat = mem_req_q & mem.mem_ready;

  // One counter serves both phases: it is reloaded with the fetch start
  // index on the final writeback beat so the request never drops between them.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_start = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          cnt_load  = 1'b1;
          cnt_start = wb_dirty ? '0 : miss_start_d;
        end
      end
      ST_WRITEBACK: begin
        if (beat) begin
          if (cnt_last) begin
            cnt_load  = 1'b1;
            cnt_start = miss_start_q;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_REFILL: cnt_inc = beat;
      default:   cnt_inc = 1'b0;
    endcase
  end

  cache_refill_beat_cnt #(
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .start (cnt_start),
    .idx   (cnt_idx),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      wb_blk_q      <= '0;
      miss_blk_q    <= '0;
      miss_start_q  <= '0;
      refill_we_q   <= 1'b0;
      refill_done_q <= 1'b0;
      refill_idx_q  <= '0;
      refill_data_q <= '0;
    end else begin
      refill_we_q   <= 1'b0;
      refill_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (miss_req) begin
            wb_blk_q     <= wb_addr[ADDR_W-1:OW];
            miss_blk_q   <= miss_addr[ADDR_W-1:OW];
            miss_start_q <= miss_start_d;
            mem_req_q    <= 1'b1;
            mem_we_q     <= wb_dirty;
            state_q      <= wb_dirty ? ST_WRITEBACK : ST_REFILL;
          end
        end
        ST_WRITEBACK: begin
          if (beat && cnt_last) begin
            mem_we_q <= 1'b0;
            state_q  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (beat) begin
            refill_we_q   <= 1'b1;
            refill_idx_q  <= cnt_idx;
            refill_data_q <= mem.mem_rdata;
            if (cnt_last) begin
              mem_req_q     <= 1'b0;
              refill_done_q <= 1'b1;
              state_q       <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = {(mem_we_q ? wb_blk_q : miss_blk_q), cnt_idx, {WORD_OFF_W{1'b0}}};
  // Victim word is read combinationally through wb_word_idx, which is
  // registered, so the write data holds steady until the beat.
  assign mem.mem_wdata = mem_we_q ? wb_word : '0;

  assign wb_word_idx     = cnt_idx;
  assign refill_we       = refill_we_q;
  assign refill_word_idx = refill_idx_q;
  assign refill_data     = refill_data_q;
  assign refill_done     = refill_done_q;
  assign busy            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: bench for cache_refill_ctrl. A behavioural memory
// and victim line answer the controller; the expected beat list, refill
// writes and latency are derived from the block/word arithmetic of the
// refill protocol.
module tb_cache_refill_ctrl;
  localparam int          ADDR_W   = 32;
  localparam int          BW       = 8;
  localparam logic [31:0] BLK_MASK = ~32'(BW * 4 - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        wb_dirty;
  logic [31:0] wb_addr;
  logic [2:0]  wb_word_idx;
  logic [31:0] wb_word;
  logic        refill_we;
  logic [2:0]  refill_word_idx;
  logic [31:0] refill_data;
  logic        refill_done;
  logic        busy;
  logic        mem_ready_r;
  logic [31:0] victim [BW];

  int n_tests = 0;
  int n_fail  = 0;

  cache_refill_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

  cache_refill_ctrl #(
    .ADDR_W      (ADDR_W),
    .BLOCK_WORDS (BW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .miss_req        (miss_req),
    .miss_addr       (miss_addr),
    .wb_dirty        (wb_dirty),
    .wb_addr         (wb_addr),
    .wb_word_idx     (wb_word_idx),
    .wb_word         (wb_word),
    .refill_we       (refill_we),
    .refill_word_idx (refill_word_idx),
    .refill_data     (refill_data),
    .refill_done     (refill_done),
    .busy            (busy),
    .mem             (mem_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_bus.mem_rdata = mem_fn(mem_bus.mem_addr);
  assign mem_bus.mem_ready = mem_ready_r;
  assign wb_word           = victim[wb_word_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_zero();
    chk("z_busy",        32'(busy), 0);
    chk("z_mem_req",     32'(mem_bus.mem_req), 0);
    chk("z_mem_we",      32'(mem_bus.mem_we), 0);
    chk("z_mem_addr",    mem_bus.mem_addr, 0);
    chk("z_mem_wdata",   mem_bus.mem_wdata, 0);
    chk("z_refill_we",   32'(refill_we), 0);
    chk("z_refill_done", 32'(refill_done), 0);
    chk("z_wb_idx",      32'(wb_word_idx), 0);
    chk("z_refill_idx",  32'(refill_word_idx), 0);
    chk("z_refill_data", refill_data, 0);
  endtask

  function automatic int pick_wait(input int b, input int fb, input int fn, input int mw);
    if (b == fb) return fn;
    return int'($urandom_range(mw, 0));
  endfunction

  // Starts from a negedge with the controller idle; returns at a negedge.
  task automatic run_miss(input bit dirty, input logic [31:0] waddr, input logic [31:0] maddr,
                          input int max_wait, input int force_beat, input int force_n,
                          input bit toggle, input int abort_beat, output int lat);
    bit          q_we[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          start, total, cyc, waits, beat_no, waits_left;
    bit          pend, done, aborted, hold_v, hold_we, ew;
    logic [31:0] pdata, hold_a, hold_d, a, ed;
    logic [2:0]  pidx;

    lat = 0;
    for (int i = 0; i < BW; i++) victim[i] = $urandom;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    start = int'(maddr[4:2]);
`else
    start = 0;
`endif
    if (dirty) begin
      for (int i = 0; i < BW; i++) begin
        q_we.push_back(1'b1);
        q_addr.push_back((waddr & BLK_MASK) | 32'(i * 4));
        q_data.push_back(victim[i]);
      end
    end
    for (int i = 0; i < BW; i++) begin
      q_we.push_back(1'b0);
      q_addr.push_back((maddr & BLK_MASK) | 32'(((start + i) % BW) * 4));
      q_data.push_back(32'h0);
    end
    total = q_addr.size();

    miss_req    = 1'b1;
    miss_addr   = maddr;
    wb_dirty    = dirty;
    wb_addr     = waddr;
    mem_ready_r = 1'($urandom);
    @(posedge clk);

    cyc = 0; waits = 0; beat_no = 0; pend = 0; done = 0; aborted = 0; hold_v = 0;
    hold_we = 0; hold_a = 0; hold_d = 0; pdata = 0; pidx = 0;
    waits_left = pick_wait(0, force_beat, force_n, max_wait);

    while (!done && !aborted && cyc < 500) begin
      @(negedge clk);
      cyc++;
      chk("busy", 32'(busy), 1);
      chk("refill_we", 32'(refill_we), 32'(pend));
      if (pend) begin
        chk("refill_idx", 32'(refill_word_idx), 32'(pidx));
        chk("refill_data", refill_data, pdata);
      end
      chk("refill_done", 32'(refill_done), 32'(pend && q_addr.size() == 0));
      chk("mem_req", 32'(mem_bus.mem_req), 32'(q_addr.size() != 0));
      if (hold_v) begin
        chk("hold_addr", mem_bus.mem_addr, hold_a);
        chk("hold_we", 32'(mem_bus.mem_we), 32'(hold_we));
        chk("hold_wdata", mem_bus.mem_wdata, hold_d);
      end
      hold_v = 0;
      pend   = 0;
      if (refill_done) begin
        done = 1;
        lat  = cyc;
        chk("latency", 32'(cyc), 32'(total + waits + 1));
        miss_req    = 1'b0;
        mem_ready_r = 1'($urandom);
      end else if (mem_bus.mem_req && q_addr.size() != 0) begin
        if (waits_left > 0) begin
          waits_left--;
          waits++;
          mem_ready_r = 1'b0;
          hold_v  = 1;
          hold_a  = mem_bus.mem_addr;
          hold_we = mem_bus.mem_we;
          hold_d  = mem_bus.mem_wdata;
        end else if (beat_no == abort_beat) begin
          mem_ready_r = 1'b1;
          reset = 1'b0;
          #1;
          check_idle_zero();
          aborted = 1;
        end else begin
          mem_ready_r = 1'b1;
          a  = q_addr.pop_front();
          ew = q_we.pop_front();
          ed = q_data.pop_front();
          chk("beat_we", 32'(mem_bus.mem_we), 32'(ew));
          chk("beat_addr", mem_bus.mem_addr, a);
          if (ew) begin
            chk("beat_wdata", mem_bus.mem_wdata, ed);
          end else begin
            pend  = 1;
            pidx  = a[4:2];
            pdata = mem_fn(a);
          end
          beat_no++;
          waits_left = pick_wait(beat_no, force_beat, force_n, max_wait);
        end
      end else begin
        mem_ready_r = 1'($urandom);
      end
      if (toggle && !done && !aborted) begin
        miss_req  = 1'($urandom);
        miss_addr = $urandom;
        wb_dirty  = 1'($urandom);
        wb_addr   = $urandom;
      end
    end
    chk("finished", 32'(done | aborted), 1);
    if (done) begin
      @(negedge clk);
      chk("busy_after", 32'(busy), 0);
      chk("single_done", 32'(refill_done), 0);
      chk("mem_req_after", 32'(mem_bus.mem_req), 0);
    end
  endtask

  initial begin
    int lat;
    reset       = 1'b0;
    miss_req    = 1'b0;
    miss_addr   = '0;
    wb_dirty    = 1'b0;
    wb_addr     = '0;
    mem_ready_r = 1'b0;
    for (int i = 0; i < BW; i++) victim[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_zero();
    reset = 1'b1;
    @(negedge clk);

    run_miss(1'b0, 32'h0, 32'h0000_1234, 0, -1, 0, 1'b0, -1, lat);
    chk("lat_clean", 32'(lat), 9);
    run_miss(1'b1, 32'h0000_8000, 32'h0000_1234, 0, -1, 0, 1'b0, -1, lat);
    chk("lat_dirty", 32'(lat), 17);
    run_miss(1'b0, 32'h0, 32'h0000_1234, 0, 2, 3, 1'b0, -1, lat);
    chk("lat_wait3", 32'(lat), 12);
    run_miss(1'b0, 32'h0, 32'h0000_4447, 0, -1, 0, 1'b1, -1, lat);
    chk("lat_toggle", 32'(lat), 9);

    run_miss(1'b0, 32'h0, 32'h0000_2000, 0, -1, 0, 1'b0, 4, lat);
    miss_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      mem_ready_r = 1'($urandom);
      @(negedge clk);
      chk("post_rst_req", 32'(mem_bus.mem_req), 0);
      chk("post_rst_we", 32'(refill_we), 0);
    end
    run_miss(1'b0, 32'h0, 32'h0000_2000, 0, -1, 0, 1'b0, -1, lat);
    chk("lat_after_rst", 32'(lat), 9);

    repeat (25) begin
      run_miss(1'($urandom), $urandom, $urandom, int'($urandom_range(3, 0)), -1, 0,
               1'($urandom), -1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width in bits.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8: 32-bit words per cache block, a power of two (32-byte block).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port miss_req, input, 1: cache requests a refill; held until refill_done.
REQ-006 SHALL have port miss_addr, input, ADDR_W: byte address that missed.
REQ-007 SHALL have port wb_dirty, input, 1: victim line is dirty; sampled with miss_req.
REQ-008 SHALL have port wb_addr, input, ADDR_W: victim block address; sampled with miss_req.
REQ-009 SHALL have port wb_word_idx, output, log2(BLOCK_WORDS): victim word being read from the cache.
REQ-010 SHALL have port wb_word, input, 32: victim word, combinationally returned for wb_word_idx.
REQ-011 SHALL have port refill_we, output, 1: write refill_data into the cache line.
REQ-012 SHALL have port refill_word_idx, output, log2(BLOCK_WORDS): target word of refill_we.
REQ-013 SHALL have port refill_data, output, 32: refill word.
REQ-014 SHALL have port refill_done, output, 1: one-cycle pulse, line complete.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_rdata (input, 32) and mem_ready (input, 1), forming the single-word memory handshake.

Function
REQ-017 SHALL implement FSM states IDLE, WRITEBACK, REFILL, DONE.
REQ-018 IDLE: miss_req=1 SHALL capture the addresses and go to WRITEBACK if wb_dirty=1, else to REFILL.
REQ-019 miss_req SHALL be ignored outside IDLE.
REQ-020 A beat SHALL be a cycle with mem_req=1 and mem_ready=1; mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the beat.
REQ-021 mem_ready while mem_req=0 SHALL be ignored.
REQ-022 WRITEBACK: mem_we=1, mem_addr={wb_addr block bits, wb_word_idx, 2'b00}, mem_wdata=wb_word.
REQ-023 WRITEBACK: idx SHALL run 0..BLOCK_WORDS-1, advancing one per beat; after the last beat go to REFILL.
REQ-024 REFILL: mem_we=0, mem_addr={miss_addr block bits, fetch idx, 2'b00}.
REQ-025 REFILL: each beat SHALL register mem_rdata; the next cycle refill_we=1 with that data and idx.
REQ-026 REFILL: fetch idx SHALL increment modulo BLOCK_WORDS (wraps 7->0); after BLOCK_WORDS beats go to DONE.
REQ-027 DONE: the last refill_we and refill_done SHALL be high together for one cycle, then the FSM returns to IDLE.
REQ-028 Latency with zero-wait memory SHALL be: refill_done 9 cycles after the accept edge for a clean line, 17 for a dirty line; each wait cycle adds one cycle.
REQ-029 The miss_addr offset bits [1:0] SHALL be ignored.

Reset
REQ-030 reset low SHALL asynchronously force IDLE and drive busy, mem_req, mem_we, refill_we, refill_done, wb_word_idx, refill_word_idx, refill_data, mem_addr and mem_wdata to 0.
REQ-031 Reset mid-burst SHALL abandon the transfer with no further beats or refill writes; the cache SHALL re-request.

Configuration
REQ-032 With CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined, the refill start idx SHALL be miss_addr[4:2] and wrap modulo BLOCK_WORDS.
REQ-033 Without CACHE_REFILL_CRITICAL_WORD_FIRST_EN, the refill start idx SHALL be 0; the writeback order SHALL be 0-first in both cases.

Structure
REQ-034 Package cache_pkg SHALL hold the FSM state enum, BLOCK_WORDS and the offset/index width constants shared with cache.
REQ-035 A sub-module cache_refill_beat_cnt (wrap counter with load-start, inc-on-beat and last flag) SHALL be used for both phases.

Verification
REQ-036 Clean miss, miss_addr=0x0000_1234, mem_ready=1 -> mem_addr 0x1220..0x123C; refill_done at cycle 9; 8 refill_we pulses.
REQ-037 Dirty miss, wb_addr=0x0000_8000 -> 8 write beats 0x8000..0x801C with mem_wdata=wb_word[idx], then refill; refill_done at cycle 17.
REQ-038 mem_ready low 3 cycles on beat 2 -> mem_addr and mem_req held; refill_done at cycle 12.
REQ-039 CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined, miss_addr=0x0000_1234 -> fetch order idx 5,6,7,0,1,2,3,4; first refill_word_idx=5.
REQ-040 Reset low during beat 4 -> all outputs 0 in the same cycle; a new miss_req after release completes a normal refill.
REQ-041 miss_req toggled while busy=1 -> no second capture; exactly one refill_done.
